// File: rtl/cgra_test_driver.sv
// cgra_test_driver: streams config beats to a CGRA, then drives per-side pad stimulus for MAX_CYCLES cycles
// Ports: clk_in/reset_in (async active-low), start_in/abort_in control; cfg_valid/ready/last/addr/data_in
// config stream in, config_addr/data_out to the CGRA; side_mode/seed_in select per-side stimulus on
// pad_data_out; pad_data_in feeds sig_out; cycle_count_out, state_out, done_out report progress.
// Optional macro SIGNATURE_EN adds per-side rotate-xor output signatures (otherwise sig_out is 0).
module cgra_test_driver #(
  parameter int NUM_SIDES  = 4,
  parameter int DATA_W     = 16,
  parameter int CFG_AW     = 32,
  parameter int CFG_DW     = 32,
  parameter int CYC_W      = 64,
  parameter int MAX_CYCLES = 2000
) (
  input  logic                        clk_in,
  input  logic                        reset_in,
  input  logic                        start_in,
  input  logic                        abort_in,
  input  logic                        cfg_valid_in,
  output logic                        cfg_ready_out,
  input  logic                        cfg_last_in,
  input  logic [CFG_AW-1:0]           cfg_addr_in,
  input  logic [CFG_DW-1:0]           cfg_data_in,
  output logic [CFG_AW-1:0]           config_addr_out,
  output logic [CFG_DW-1:0]           config_data_out,
  input  logic [2*NUM_SIDES-1:0]      side_mode_in,
  input  logic [DATA_W*NUM_SIDES-1:0] side_seed_in,
  output logic [DATA_W*NUM_SIDES-1:0] pad_data_out,
  input  logic [DATA_W*NUM_SIDES-1:0] pad_data_in,
  output logic [DATA_W*NUM_SIDES-1:0] sig_out,
  output logic [CYC_W-1:0]            cycle_count_out,
  output logic [1:0]                  state_out,
  output logic                        done_out
);
  typedef enum logic [1:0] {IDLE = 2'd0, CONFIG = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
  state_t r_state, w_next;
  logic [CFG_AW-1:0] r_cfg_addr;
  logic [CFG_DW-1:0] r_cfg_data;
  logic [DATA_W*NUM_SIDES-1:0] r_pad, w_pad_load, w_pad_step;
  logic [CYC_W-1:0] r_count;
  logic w_accept, w_start, w_last_run;
  assign cfg_ready_out   = r_state == CONFIG;
  assign w_accept        = cfg_valid_in && cfg_ready_out;
  assign w_start         = start_in && (r_state == IDLE || r_state == DONE);
  assign w_last_run      = r_count == CYC_W'(MAX_CYCLES - 1);
  assign config_addr_out = r_cfg_addr;
  assign config_data_out = r_cfg_data;
  assign pad_data_out    = r_pad;
  assign cycle_count_out = r_count;
  assign state_out       = r_state;
  assign done_out        = r_state == DONE;
  always_comb begin
    w_next = r_state;
    if (abort_in) w_next = IDLE;
    else if (w_start) w_next = CONFIG;
    else if (w_accept && cfg_last_in) w_next = RUN;
    else if (r_state == RUN && w_last_run) w_next = DONE;
  end
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) r_state <= IDLE;
    else r_state <= w_next;
  for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
    logic [1:0] w_mode;
    logic [DATA_W-1:0] w_seed, w_pad;
    assign w_mode = side_mode_in[2*s +: 2];
    assign w_seed = side_seed_in[DATA_W*s +: DATA_W];
    assign w_pad  = r_pad[DATA_W*s +: DATA_W];
    assign w_pad_load[DATA_W*s +: DATA_W] = w_mode == 2'b00 ? '0 : w_seed;
    assign w_pad_step[DATA_W*s +: DATA_W] = w_mode == 2'b00 ? '0 :
                                            w_mode == 2'b01 ? w_seed :
                                            w_mode == 2'b10 ? w_pad + DATA_W'(1) : w_pad - DATA_W'(1);
  end
  // Abort only clears the config outputs; pads and counter keep their values.
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) begin
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
      r_pad      <= '0;
      r_count    <= '0;
    end else begin
      r_cfg_addr <= (!abort_in && w_accept) ? cfg_addr_in : '0;
      r_cfg_data <= (!abort_in && w_accept) ? cfg_data_in : '0;
      if (!abort_in && w_start) begin
        r_count <= '0;
        r_pad   <= w_pad_load;
      end else if (!abort_in && r_state == RUN) begin
        r_count <= r_count + CYC_W'(1);
        r_pad   <= w_pad_step;
      end
    end
`ifdef SIGNATURE_EN
  logic [DATA_W*NUM_SIDES-1:0] r_sig, w_sig_step;
  for (genvar s = 0; s < NUM_SIDES; s++) begin : g_sig
    logic [DATA_W-1:0] w_cur;
    assign w_cur = r_sig[DATA_W*s +: DATA_W];
    assign w_sig_step[DATA_W*s +: DATA_W] = {w_cur[DATA_W-2:0], w_cur[DATA_W-1]} ^ pad_data_in[DATA_W*s +: DATA_W];
  end
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) r_sig <= '0;
    else if (!abort_in && w_start) r_sig <= '0;
    else if (!abort_in && r_state == RUN) r_sig <= w_sig_step;
  assign sig_out = r_sig;
`else
  logic w_unused_pad_in;
  assign w_unused_pad_in = ^pad_data_in;
  assign sig_out = '0;
`endif
endmodule

// File: tb/tb_cgra_test_driver.sv
// tb_cgra_test_driver: directed and random checks of cgra_test_driver against a behavioural model
module tb_cgra_test_driver;
  localparam int MAXC = 5;
  logic clk = 0, reset_in = 0, start_in = 0, abort_in = 0;
  logic cfg_valid_in = 0, cfg_last_in = 0, cfg_ready_out, done_out;
  logic [31:0] cfg_addr_in = 0, cfg_data_in = 0, config_addr_out, config_data_out;
  logic [7:0] side_mode_in = 0;
  logic [63:0] side_seed_in = 0, pad_data_in = 0, pad_data_out, sig_out, cycle_count_out;
  logic [1:0] state_out;
  int errors = 0, checks = 0;
  int ph = 0;
  longint unsigned cnt = 0;
  int unsigned mpad[4], msig[4];
  logic [31:0] ma = 0, md = 0;

  always #5 clk = ~clk;

  cgra_test_driver #(.NUM_SIDES(4), .DATA_W(16), .CFG_AW(32), .CFG_DW(32), .CYC_W(64), .MAX_CYCLES(MAXC)) dut (
    .clk_in(clk), .reset_in(reset_in), .start_in(start_in), .abort_in(abort_in),
    .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out), .cfg_last_in(cfg_last_in),
    .cfg_addr_in(cfg_addr_in), .cfg_data_in(cfg_data_in),
    .config_addr_out(config_addr_out), .config_data_out(config_data_out),
    .side_mode_in(side_mode_in), .side_seed_in(side_seed_in),
    .pad_data_out(pad_data_out), .pad_data_in(pad_data_in), .sig_out(sig_out),
    .cycle_count_out(cycle_count_out), .state_out(state_out), .done_out(done_out));

  function automatic int unsigned mode(int s); return side_mode_in[2*s +: 2]; endfunction
  function automatic int unsigned seed(int s); return side_seed_in[16*s +: 16]; endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    ph = 0; cnt = 0; ma = 0; md = 0;
    for (int s = 0; s < 4; s++) begin mpad[s] = 0; msig[s] = 0; end
  endtask

  task automatic check_all;
    logic [63:0] ep, es;
    ep = 0; es = 0;
    for (int s = 0; s < 4; s++) begin
      ep[16*s +: 16] = mpad[s][15:0];
`ifdef SIGNATURE_EN
      es[16*s +: 16] = msig[s][15:0];
`endif
    end
    chk("state", 64'(state_out), 64'(ph));
    chk("ready", 64'(cfg_ready_out), 64'(ph == 1));
    chk("done", 64'(done_out), 64'(ph == 3));
    chk("cfg_addr", 64'(config_addr_out), 64'(ma));
    chk("cfg_data", 64'(config_data_out), 64'(md));
    chk("count", cycle_count_out, cnt);
    chk("pad", pad_data_out, ep);
    chk("sig", sig_out, es);
  endtask

  // Advance one clock edge, predicting its effect from the inputs currently applied.
  task automatic tick;
    int np;
    logic [31:0] na, nd;
    np = ph; na = 0; nd = 0;
    if (abort_in) np = 0;
    else if ((ph == 0 || ph == 3) && start_in) begin
      np = 1; cnt = 0;
      for (int s = 0; s < 4; s++) begin msig[s] = 0; mpad[s] = mode(s) == 0 ? 0 : seed(s); end
    end else if (ph == 1 && cfg_valid_in) begin
      na = cfg_addr_in; nd = cfg_data_in;
      if (cfg_last_in) np = 2;
    end else if (ph == 2) begin
      for (int s = 0; s < 4; s++) begin
        case (mode(s))
          0: mpad[s] = 0;
          1: mpad[s] = seed(s);
          2: mpad[s] = (mpad[s] + 1) % 65536;
          default: mpad[s] = (mpad[s] + 65535) % 65536;
        endcase
        msig[s] = (((msig[s] << 1) | (msig[s] >> 15)) & 16'hFFFF) ^ pad_data_in[16*s +: 16];
      end
      cnt++;
      if (cnt == MAXC) np = 3;
    end
    ph = np; ma = na; md = nd;
    @(posedge clk); #1;
    check_all;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic last);
    cfg_valid_in = 1; cfg_addr_in = a; cfg_data_in = d; cfg_last_in = last;
    tick;
    cfg_valid_in = 0; cfg_last_in = 0;
  endtask

  initial begin
    model_reset;
    #2 check_all;
    @(posedge clk); #1 check_all;
    reset_in = 1;
    side_mode_in = 8'b01_10_10_11;
    side_seed_in = {16'h1234, 16'h0003, 16'hFFFF, 16'h0001};
    pad_data_in = {4{16'h0001}};
    start_in = 1; tick; start_in = 0;
    beat(32'h10, 32'hA, 0); chk("beat1_addr", 64'(config_addr_out), 64'h10);
    tick; chk("gap_addr", 64'(config_addr_out), 64'h0);
    beat(32'h20, 32'hB, 0); chk("beat2_addr", 64'(config_addr_out), 64'h20);
    beat(32'h30, 32'hC, 1); chk("beat3_addr", 64'(config_addr_out), 64'h30);
    chk("run_entry", 64'(state_out), 64'd2);
    start_in = 1;
    tick;
    chk("side2_r1", 64'(pad_data_out[47:32]), 64'd4);
    chk("side0_r1", 64'(pad_data_out[15:0]), 64'h0000);
    chk("side1_r1", 64'(pad_data_out[31:16]), 64'h0000);
`ifdef SIGNATURE_EN
    chk("sig_r1", 64'(sig_out[15:0]), 64'h1);
`else
    chk("sig_r1", 64'(sig_out[15:0]), 64'h0);
`endif
    start_in = 0;
    tick;
    chk("side0_r2", 64'(pad_data_out[15:0]), 64'hFFFF);
`ifdef SIGNATURE_EN
    chk("sig_r2", 64'(sig_out[15:0]), 64'h3);
`else
    chk("sig_r2", 64'(sig_out[15:0]), 64'h0);
`endif
    repeat (3) tick;
    chk("side2_done", 64'(pad_data_out[47:32]), 64'd8);
    chk("done_hi", 64'(done_out), 64'd1);
    chk("count_done", cycle_count_out, 64'd5);
    repeat (2) tick;
    chk("count_frozen", cycle_count_out, 64'd5);
    start_in = 1; tick;
    chk("restart_count", cycle_count_out, 64'd0);
    tick; chk("start_in_cfg", 64'(state_out), 64'd1);
    beat(32'h44, 32'h55, 1);
    start_in = 0;
    repeat (2) tick;
    chk("count_before_abort", cycle_count_out, 64'd2);
    abort_in = 1; tick; abort_in = 0;
    chk("abort_idle", 64'(state_out), 64'd0);
    chk("abort_count", cycle_count_out, 64'd2);
    tick;
    start_in = 1; tick; start_in = 0;
    beat(32'h77, 32'h88, 0);
    tick;
    reset_in = 0; #1;
    model_reset; check_all;
    chk("reset_ready", 64'(cfg_ready_out), 64'd0);
    @(posedge clk); #1 reset_in = 1;
    for (int i = 0; i < 400; i++) begin
      abort_in = $urandom_range(19) == 0;
      start_in = $urandom_range(3) == 0;
      cfg_valid_in = $urandom_range(1) == 1;
      cfg_last_in = $urandom_range(3) == 0;
      cfg_addr_in = $urandom; cfg_data_in = $urandom;
      if ($urandom_range(7) == 0) side_mode_in = 8'($urandom);
      if ($urandom_range(7) == 0) side_seed_in = {$urandom, $urandom};
      pad_data_in = {$urandom, $urandom};
      tick;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
